// File: rtl/soc_ctrl_clk_rst_seq_pkg.sv
// Shared types and constants for the per-domain clock/reset sequencer.
// Optional build macro used by the sequencer: SOC_CTRL_LOCK_LOSS_RST_EN.
package soc_ctrl_pkg;

    // Depth of the PLL lock synchronizer.
    localparam int SOC_CTRL_SYNC_STAGES = 2;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_CLK_DLY   = 3'd2,
        ST_RUN       = 3'd3,
        ST_RST_DLY   = 3'd4
    } soc_ctrl_seq_state_e;

    // True in the two timed states, where busy is reported.
    function automatic logic seq_is_delay(input soc_ctrl_seq_state_e st);
        return (st == ST_CLK_DLY) || (st == ST_RST_DLY);
    endfunction

endpackage

// File: rtl/soc_ctrl_clk_rst_seq_if.sv
// Request/status bundle between software control and the domain sequencer.
// The master drives the requests and the PLL lock; the slave (the sequencer)
// drives the domain clock gate, the domain reset and busy.
interface soc_ctrl_clk_rst_seq_if;
    logic dom_rst_i;
    logic clk_en_i;
    logic pll_lock_i;
    logic clk_en_o;
    logic dom_rst_o;
    logic busy_o;

    modport master (
        output dom_rst_i, clk_en_i, pll_lock_i,
        input  clk_en_o, dom_rst_o, busy_o
    );

    modport slave (
        input  dom_rst_i, clk_en_i, pll_lock_i,
        output clk_en_o, dom_rst_o, busy_o
    );
endinterface

// File: rtl/soc_ctrl_clk_rst_seq_sync.sv
// Generic N-flop single-bit synchronizer with synchronous reset to 0.
// STAGES must be at least 2.
module soc_ctrl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/soc_ctrl_clk_rst_seq.sv
// Per-domain clock-enable / reset sequencer on the reference clock.
// Power-up: wait for synchronized PLL lock, enable the clock, hold reset for
// DELAY_CYCLES, release. Power-down: assert reset, wait DELAY_CYCLES, gate
// the clock. Once started, a power-down always runs to completion.
// Build macro SOC_CTRL_LOCK_LOSS_RST_EN: when defined, losing lock while the
// clock is enabled starts a power-down; otherwise lock is only checked
// before enabling.
module soc_ctrl_clk_rst_seq
    import soc_ctrl_pkg::*;
#(
    parameter int DELAY_CYCLES = 50
) (
    input  logic                clk_i,
    input  logic                rst_i,
    soc_ctrl_clk_rst_seq_if.slave ctrl_if,
    output soc_ctrl_seq_state_e state_o
);

    localparam int CNT_W = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);

    soc_ctrl_seq_state_e state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                lock_s;
    logic                req_ok;
    logic                keep_ok;

    soc_ctrl_sync #(
        .STAGES (SOC_CTRL_SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ctrl_if.pll_lock_i),
        .q_o   (lock_s)
    );

    // A domain reset request outranks the clock-enable request.
    assign req_ok = ctrl_if.clk_en_i && !ctrl_if.dom_rst_i;

`ifdef SOC_CTRL_LOCK_LOSS_RST_EN
    assign keep_ok = req_ok && lock_s;
`else
    assign keep_ok = req_ok;
`endif

    // Next-state and delay counter; a drop during CLK_DLY wins over reaching RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_OFF: begin
                if (req_ok) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!req_ok) begin
                    state_d = ST_OFF;
                end else if (lock_s) begin
                    state_d = ST_CLK_DLY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_CLK_DLY: begin
                if (!keep_ok) begin
                    state_d = ST_RST_DLY;
                    cnt_d   = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!keep_ok) begin
                    state_d = ST_RST_DLY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_RST_DLY: begin
                if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode the state register only, so they are glitch-free.
    assign ctrl_if.clk_en_o  = (state_q == ST_CLK_DLY) || (state_q == ST_RUN) ||
                               (state_q == ST_RST_DLY);
    assign ctrl_if.dom_rst_o = (state_q != ST_RUN);
    assign ctrl_if.busy_o    = seq_is_delay(state_q);
    assign state_o           = state_q;

endmodule

// File: tb/tb_soc_ctrl_clk_rst_seq.sv
// Bench for the domain clock/reset sequencer: directed power-up/down, abort
// and lock-loss scenarios, then randomized request traffic, all shadowed by
// a cycle-level reference model feeding an expected-value queue.
module tb_soc_ctrl_clk_rst_seq;
    import soc_ctrl_pkg::*;

    localparam int DELAY = 50;

    logic clk = 1'b0;
    logic rst;
    soc_ctrl_seq_state_e state_dbg;

    soc_ctrl_clk_rst_seq_if ctrl_if ();

    soc_ctrl_clk_rst_seq #(
        .DELAY_CYCLES (DELAY)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .ctrl_if (ctrl_if),
        .state_o (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- counters / checks ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [5:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Phase plus the edge at which the current timed phase began; a timed
    // phase ends DELAY edges after it started.
    function automatic logic [5:0] expect_of(input soc_ctrl_seq_state_e ph);
        logic ce, dr, bz;
        ce = 1'b0; dr = 1'b1; bz = 1'b0;
        case (ph)
            ST_CLK_DLY: begin ce = 1'b1; dr = 1'b1; bz = 1'b1; end
            ST_RUN:     begin ce = 1'b1; dr = 1'b0; bz = 1'b0; end
            ST_RST_DLY: begin ce = 1'b1; dr = 1'b1; bz = 1'b1; end
            default:    begin ce = 1'b0; dr = 1'b1; bz = 1'b0; end
        endcase
        return {3'(ph), ce, dr, bz};
    endfunction

    initial begin
        soc_ctrl_seq_state_e m_ph;
        int   edge_no;
        int   t0;
        logic lk, req, keep;
        logic lock_pipe[$];
        m_ph = ST_OFF;
        edge_no = 0;
        t0 = 0;
        lock_pipe.push_back(1'b0);
        lock_pipe.push_back(1'b0);
        forever begin
            @(posedge clk);
            edge_no++;
            // Lock as seen by the sequencer: the input from two edges ago.
            lk = lock_pipe[0];
            void'(lock_pipe.pop_front());
            lock_pipe.push_back(ctrl_if.pll_lock_i);
            if (rst) begin
                m_ph = ST_OFF;
                lock_pipe.delete();
                lock_pipe.push_back(1'b0);
                lock_pipe.push_back(1'b0);
            end else begin
                req = ctrl_if.clk_en_i && !ctrl_if.dom_rst_i;
`ifdef SOC_CTRL_LOCK_LOSS_RST_EN
                keep = req && lk;
`else
                keep = req;
`endif
                case (m_ph)
                    ST_OFF: if (req) m_ph = ST_WAIT_LOCK;
                    ST_WAIT_LOCK: begin
                        if (!req) m_ph = ST_OFF;
                        else if (lk) begin m_ph = ST_CLK_DLY; t0 = edge_no; end
                    end
                    ST_CLK_DLY: begin
                        if (!keep) begin m_ph = ST_RST_DLY; t0 = edge_no; end
                        else if (edge_no - t0 == DELAY) m_ph = ST_RUN;
                    end
                    ST_RUN: if (!keep) begin m_ph = ST_RST_DLY; t0 = edge_no; end
                    ST_RST_DLY: if (edge_no - t0 == DELAY) m_ph = ST_OFF;
                    default: m_ph = ST_OFF;
                endcase
            end
            exp_q.push_back(expect_of(m_ph));
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [5:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {3'(state_dbg), ctrl_if.clk_en_o, ctrl_if.dom_rst_o, ctrl_if.busy_o};
                total_cnt++;
                if (a === e) pass_cnt++;
                else $display("FAIL scoreboard t=%0t: got st=%0d ce/dr/bz=%b, expected st=%0d ce/dr/bz=%b",
                              $time, a[5:3], a[2:0], e[5:3], e[2:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // which: 0 clk_en_o, 1 dom_rst_o, 2 busy_o. n = ticks taken, -1 on timeout.
    task automatic wait_for(input int which, input logic val, input int max_cyc, output int n);
        logic s;
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            s = (which == 0) ? ctrl_if.clk_en_o :
                (which == 1) ? ctrl_if.dom_rst_o : ctrl_if.busy_o;
            if (s == val) begin
                n = i;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, t_clk, t_rst, busy_n, bad;
        rst = 1'b1;
        ctrl_if.clk_en_i   = 1'b0;
        ctrl_if.dom_rst_i  = 1'b0;
        ctrl_if.pll_lock_i = 1'b0;

        // Reset with inputs toggling.
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            ctrl_if.clk_en_i   = 1'($urandom_range(0, 1));
            ctrl_if.dom_rst_i  = 1'($urandom_range(0, 1));
            ctrl_if.pll_lock_i = 1'($urandom_range(0, 1));
            tick();
            if (ctrl_if.clk_en_o !== 1'b0 || ctrl_if.dom_rst_o !== 1'b1 ||
                ctrl_if.busy_o !== 1'b0) bad++;
        end
        check("reset_outputs", bad, 0);
        rst = 1'b0;
        ctrl_if.clk_en_i   = 1'b0;
        ctrl_if.dom_rst_i  = 1'b0;
        ctrl_if.pll_lock_i = 1'b0;
        tick();
        check("post_reset_state", int'(state_dbg), int'(ST_OFF));
        tick(4);

        // No lock: request held, lock never arrives.
        ctrl_if.clk_en_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ctrl_if.clk_en_o !== 1'b0) bad++;
        end
        check("nolock_clk_en_low", bad, 0);
        check("nolock_state", int'(state_dbg), int'(ST_WAIT_LOCK));
        ctrl_if.clk_en_i = 1'b0;
        tick();
        check("nolock_drop_off", int'(state_dbg), int'(ST_OFF));

        // Power-up: lock rises 20 cycles after the request.
        ctrl_if.clk_en_i = 1'b1;
        tick(20);
        ctrl_if.pll_lock_i = 1'b1;
        t_clk = -1; t_rst = -1; busy_n = 0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (t_clk < 0 && ctrl_if.clk_en_o === 1'b1) t_clk = i;
            if (t_rst < 0 && ctrl_if.dom_rst_o === 1'b0) t_rst = i;
            if (ctrl_if.busy_o === 1'b1) busy_n++;
        end
        check("pwrup_clk_en_latency", t_clk, 3);
        check("pwrup_dom_rst_latency", t_rst, 3 + DELAY);
        check("pwrup_busy_cycles", busy_n, DELAY);

        // Power-down from RUN.
        ctrl_if.clk_en_i = 1'b0;
        tick();
        check("pwrdn_dom_rst_next", int'(ctrl_if.dom_rst_o), 1);
        wait_for(0, 1'b0, 100, n);
        check("pwrdn_clk_en_latency", n + 1, 1 + DELAY);

        // Abort during CLK_DLY at its 10th cycle.
        ctrl_if.clk_en_i = 1'b1;
        wait_for(2, 1'b1, 10, n);
        check("abort_enter_clk_dly", n, 2);
        tick(9);
        ctrl_if.dom_rst_i = 1'b1;
        wait_for(0, 1'b0, 100, n);
        check("abort_rst_dly_len", n, 1 + DELAY);
        check("abort_state_off", int'(state_dbg), int'(ST_OFF));
        ctrl_if.dom_rst_i = 1'b0;
        wait_for(1, 1'b0, 100, n);
        check("abort_restart_run", n, 2 + DELAY);

        // Lock loss while in RUN.
        ctrl_if.pll_lock_i = 1'b0;
`ifdef SOC_CTRL_LOCK_LOSS_RST_EN
        wait_for(1, 1'b1, 10, n);
        check("lockloss_dom_rst", n, 3);
        wait_for(0, 1'b0, 100, n);
        check("lockloss_clk_en", n, DELAY);
`else
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ctrl_if.dom_rst_o !== 1'b0 || ctrl_if.clk_en_o !== 1'b1) bad++;
        end
        check("lockloss_ignored", bad, 0);
`endif

        // Randomized traffic, checked by the scoreboard.
        for (int seg = 0; seg < 60; seg++) begin
            rst                = ($urandom_range(0, 19) == 0);
            ctrl_if.clk_en_i   = ($urandom_range(0, 3) != 0);
            ctrl_if.dom_rst_i  = ($urandom_range(0, 5) == 0);
            ctrl_if.pll_lock_i = ($urandom_range(0, 4) != 0);
            tick($urandom_range(1, 120));
        end
        rst = 1'b0;
        tick(3);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/soc_ctrl_clk_rst_seq.md
Name: soc_ctrl_clk_rst_seq

Overview:
- Per-domain clock-enable / reset sequencer in the SoC control block.
- Runs on the reference clock and watches the domain PLL lock and a software clock-enable request.
- Power-up order: enable the domain clock after lock, hold domain reset for DELAY_CYCLES, then release it.
- Power-down order: assert domain reset, wait DELAY_CYCLES, then disable the clock.

Parameters:
- DELAY_CYCLES, default 50: reference-clock cycles between clock-enable and reset edges. Legal range 1..65535.

Ports:
- clk_i  input  1  reference clock; the only clock of the block.
- rst_i  input  1  synchronous, active-high global reset.
- dom_rst_i  input  1  synchronous, active-high domain reset request.
- clk_en_i  input  1  domain clock-enable request.
- pll_lock_i  input  1  PLL lock, asynchronous to clk_i.
- clk_en_o  output  1  domain clock gate enable.
- dom_rst_o  output  1  domain reset, active-high.
- busy_o  output  1  high while in a DELAY state.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- While rst_i=1 and on the first cycle after it: state=OFF, clk_en_o=0, dom_rst_o=1, busy_o=0, counter=0, sync flops=0.
- pll_lock_i passes through a 2-flop synchronizer. lock_s is its output, so it lags the input by 2 cycles.
- All outputs are registered and decoded from state only.
- FSM states, with outputs (clk_en_o, dom_rst_o):
  - OFF (0,1): go to WAIT_LOCK when clk_en_i=1 and dom_rst_i=0.
  - WAIT_LOCK (0,1):
    - If clk_en_i=0 or dom_rst_i=1, return to OFF.
    - Else if lock_s=1, go to CLK_DLY and load counter = DELAY_CYCLES-1.
  - CLK_DLY (1,1), busy_o=1:
    - Decrement the counter each cycle. At counter=0, go to RUN. The state lasts exactly DELAY_CYCLES cycles.
    - If clk_en_i=0 or dom_rst_i=1 here, go to RST_DLY and reload the counter. dom_rst_o is already 1.
  - RUN (1,0): if clk_en_i=0 or dom_rst_i=1, go to RST_DLY and load counter = DELAY_CYCLES-1.
  - RST_DLY (1,1), busy_o=1:
    - Lasts exactly DELAY_CYCLES cycles, then goes to OFF.
    - Requests are ignored during this state; the sequence always completes.
- Simultaneous events:
  - dom_rst_i has priority over clk_en_i.
  - rst_i overrides everything in any state.
- Latency, pll_lock rising to dom_rst_o falling with the request held: 2 sync + 1 WAIT_LOCK + DELAY_CYCLES cycles.
- Latency, request drop to clk_en_o falling: 1 + DELAY_CYCLES cycles.
- Counter width is $clog2(DELAY_CYCLES+1). The counter never wraps; it saturates at 0.
- rst_i asserted mid-sequence forces OFF on the next edge. That edge drops clk_en_o immediately; this abrupt shutdown is accepted.

Optional Feature:
- Macro SOC_CTRL_LOCK_LOSS_RST_EN.
- Defined: lock_s=0 in CLK_DLY or RUN is treated like a request drop and enters RST_DLY.
- Undefined: lock is checked only in WAIT_LOCK, and later lock loss is ignored.

Decomposition:
- Package soc_ctrl_pkg holds:
  - the state enum soc_ctrl_seq_state_e (OFF, WAIT_LOCK, CLK_DLY, RUN, RST_DLY), 3-bit;
  - constant SOC_CTRL_SYNC_STAGES=2.
- One sub-module is natural: soc_ctrl_sync, a generic N-flop bit synchronizer with synchronous reset to 0, used for pll_lock_i.

Test Plan:
- Reset: rst_i=1 for 10 cycles, all inputs toggling -> clk_en_o=0, dom_rst_o=1, busy_o=0 throughout.
- Power-up: DELAY_CYCLES=50, clk_en_i=1, then pll_lock_i=1 at cycle 20.
  - clk_en_o rises at cycle 23.
  - dom_rst_o falls at cycle 73.
  - busy_o is high for exactly 50 cycles.
- Power-down: in RUN, clk_en_i=0 at cycle T -> dom_rst_o=1 at T+1, clk_en_o=0 at T+51.
- No lock: clk_en_i=1 with pll_lock_i=0 for 200 cycles -> stays WAIT_LOCK, clk_en_o=0. Dropping clk_en_i returns to OFF next cycle.
- Abort in CLK_DLY: dom_rst_i=1 at cycle 10 of CLK_DLY -> RST_DLY for 50 cycles, then OFF with clk_en_o=0. Re-request then restarts the full sequence.
- Lock loss in RUN, pll_lock_i=0:
  - With SOC_CTRL_LOCK_LOSS_RST_EN: dom_rst_o=1 after 3 cycles, clk_en_o=0 50 cycles later.
  - Without it: outputs unchanged.
